// File: rtl/demux8_skid.sv
// Registered 1-to-8 demultiplexer with a two-entry skid buffer (main + skid register).
// Words leave strictly in acceptance order; in_ready comes straight from a flop.
module demux8_skid #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_in_select,
    input  logic [WIDTH-1:0] i_in_data,
    output logic [7:0]       o_out_valid,
    input  logic [7:0]       i_out_ready,
    output logic [2:0]       o_out_sel,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a word moves on a rising edge where valid and ready are both 1.
    // Upstream must hold in_valid/in_select/in_data stable while in_ready is 0;
    // the selected output holds out_valid/out_sel/out_data stable until its ready bit is 1.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_in_ready;
    logic [2:0]       r_m_sel;
    logic [2:0]       r_s_sel;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;

    logic w_m_valid;
    logic w_accept;
    logic w_drain;
    logic w_load_m_in;
    logic w_load_m_s;
    logic w_load_s;

    assign w_m_valid   = (r_state != ST_EMPTY);
    assign o_out_valid = w_m_valid ? (8'b1 << r_m_sel) : 8'b0;
    assign o_out_sel   = w_m_valid ? r_m_sel : 3'd0;
    assign o_out_data  = r_m_data;
    assign o_in_ready  = r_in_ready;
    assign o_dbg_state = r_state;

    // Only the ready bit of the presented channel can drain the word.
    assign w_accept = i_in_valid & r_in_ready;
    assign w_drain  = |(o_out_valid & i_out_ready);

    always_comb begin
        w_next      = r_state;
        w_load_m_in = 1'b0;
        w_load_m_s  = 1'b0;
        w_load_s    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next      = ST_ONE;
                    w_load_m_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_m_in = 1'b1;
                end else if (w_accept) begin
                    w_next   = ST_TWO;
                    w_load_s = 1'b1;
                end else if (w_drain) begin
                    w_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_next     = ST_ONE;
                    w_load_m_s = 1'b1;
                end
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_m_sel    <= 3'd0;
            r_m_data   <= '0;
            r_s_sel    <= 3'd0;
            r_s_data   <= '0;
        end else begin
            r_state    <= w_next;
            // Registered from the next state so upstream never sees a path from out_ready.
            r_in_ready <= (w_next != ST_TWO);
            if (w_load_m_in) begin
                r_m_sel  <= i_in_select;
                r_m_data <= i_in_data;
            end else if (w_load_m_s) begin
                r_m_sel  <= r_s_sel;
                r_m_data <= r_s_data;
            end
            if (w_load_s) begin
                r_s_sel  <= i_in_select;
                r_s_data <= i_in_data;
            end
        end
    end

endmodule

// File: tb/tb_demux8_skid.sv
// Bench for demux8_skid: directed scenarios plus random traffic, checked against
// an in-order queue of expected {select, data} words.
module tb_demux8_skid;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_select;
    logic [W-1:0] in_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [2:0]   out_sel;
    logic [W-1:0] out_data;
    logic [1:0]   dbg_state;

    logic [W+2:0] exp_q[$];
    int           n_cmp;
    int           n_err;

    logic         hold_pending;
    logic [7:0]   hold_valid;
    logic [2:0]   hold_sel;
    logic [W-1:0] hold_data;

    demux8_skid #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_select (in_select),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_sel   (out_sel),
        .o_out_data  (out_data),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step: score the handshakes that the coming edge will perform, then
    // advance to the next falling edge. Inputs are only changed at falling edges.
    task automatic cycle();
        logic [W+2:0] e;
        logic [7:0]   ev;
        logic         drain;
        drain = rst_n && ((out_valid & out_ready) != 8'h00);
        if (rst_n && hold_pending) begin
            n_cmp++;
            if (out_valid !== hold_valid || out_sel !== hold_sel || out_data !== hold_data) begin
                n_err++;
                $display("FAIL hold: got valid=%h sel=%0d data=%h, required valid=%h sel=%0d data=%h",
                         out_valid, out_sel, out_data, hold_valid, hold_sel, hold_data);
            end
        end
        if (drain) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got sel=%0d data=%h, required no word", out_sel, out_data);
            end else begin
                e  = exp_q.pop_front();
                ev = 8'h01 << e[W+2:W];
                if (out_sel !== e[W+2:W] || out_data !== e[W-1:0] || out_valid !== ev) begin
                    n_err++;
                    $display("FAIL scoreboard: got valid=%h sel=%0d data=%h, required valid=%h sel=%0d data=%h",
                             out_valid, out_sel, out_data, ev, e[W+2:W], e[W-1:0]);
                end
            end
        end
        if (rst_n && in_valid && in_ready)
            exp_q.push_back({in_select, in_data});
        if (!rst_n)
            exp_q.delete();
        hold_pending = rst_n && (out_valid != 8'h00) && !drain;
        hold_valid   = out_valid;
        hold_sel     = out_sel;
        hold_data    = out_data;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] d);
        in_valid  = v;
        in_select = s;
        in_data   = d;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 8'hFF;
        drive(1'b1, 3'd4, 32'hDEAD_BEEF);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 8'h00 || out_sel !== 3'd0 || out_data !== '0) begin
                n_err++;
                $display("FAIL reset_hold: got rdy=%b valid=%h sel=%0d data=%h, required 1/00/0/0",
                         in_ready, out_valid, out_sel, out_data);
            end
        end
        rst_n = 1'b1;
        drive(1'b0, 3'd0, '0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 8'h00 || out_sel !== 3'd0 || out_data !== '0) begin
                n_err++;
                $display("FAIL reset_idle: got rdy=%b valid=%h sel=%0d data=%h, required 1/00/0/0",
                         in_ready, out_valid, out_sel, out_data);
            end
        end
    endtask

    task automatic test_single();
        out_ready = 8'hFF;
        drive(1'b1, 3'd5, 32'hA5A5_0005);
        cycle();
        drive(1'b0, 3'd0, '0);
        n_cmp++;
        if (out_valid !== 8'h20 || out_sel !== 3'd5 || out_data !== 32'hA5A5_0005) begin
            n_err++;
            $display("FAIL single_route: got valid=%h sel=%0d data=%h, required 20/5/a5a50005",
                     out_valid, out_sel, out_data);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 8'h00 || out_sel !== 3'd0) begin
            n_err++;
            $display("FAIL single_once: got valid=%h sel=%0d, required 00/0", out_valid, out_sel);
        end
    endtask

    task automatic test_stream();
        logic [7:0] ev;
        out_ready = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), W'(k));
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready k=%0d: got %b, required 1", k, in_ready);
            end
            if (k > 0) begin
                ev = 8'h01 << (k - 1);
                n_cmp++;
                if (out_valid !== ev || out_data !== W'(k - 1)) begin
                    n_err++;
                    $display("FAIL stream_out k=%0d: got valid=%h data=%h, required %h/%0d",
                             k, out_valid, out_data, ev, k - 1);
                end
            end
            cycle();
        end
        drive(1'b0, 3'd0, '0);
        n_cmp++;
        if (out_valid !== 8'h80 || out_data !== W'(7)) begin
            n_err++;
            $display("FAIL stream_last: got valid=%h data=%h, required 80/7", out_valid, out_data);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 8'h00;
        drive(1'b1, 3'd2, 32'h11);
        cycle();
        drive(1'b1, 3'd6, 32'h22);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 8'h04) begin
            n_err++;
            $display("FAIL bp_first: got rdy=%b valid=%h, required 1/04", in_ready, out_valid);
        end
        cycle();
        drive(1'b1, 3'd1, 32'h33);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 8'h04 || out_data !== 32'h11) begin
                n_err++;
                $display("FAIL bp_stall i=%0d: got rdy=%b valid=%h data=%h, required 0/04/11",
                         i, in_ready, out_valid, out_data);
            end
            cycle();
        end
        out_ready = 8'hFF;
        cycle();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 8'h40 || out_data !== 32'h22) begin
            n_err++;
            $display("FAIL bp_restart: got rdy=%b valid=%h data=%h, required 1/40/22",
                     in_ready, out_valid, out_data);
        end
        cycle();
        drive(1'b0, 3'd0, '0);
        n_cmp++;
        if (out_valid !== 8'h02 || out_data !== 32'h33) begin
            n_err++;
            $display("FAIL bp_third: got valid=%h data=%h, required 02/33", out_valid, out_data);
        end
        cycle();
    endtask

    task automatic test_wrong_channel();
        out_ready = 8'h00;
        drive(1'b1, 3'd3, 32'h3333_0003);
        cycle();
        drive(1'b0, 3'd0, '0);
        out_ready = 8'hF7;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 8'h08 || out_data !== 32'h3333_0003) begin
                n_err++;
                $display("FAIL wrong_ready i=%0d: got valid=%h data=%h, required 08/33330003",
                         i, out_valid, out_data);
            end
            cycle();
        end
        out_ready = 8'h08;
        cycle();
        n_cmp++;
        if (out_valid !== 8'h00 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrong_drain: got valid=%h pending=%0d, required 00/0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 8'h00;
        drive(1'b1, 3'd7, 32'h77);
        cycle();
        drive(1'b1, 3'd0, 32'h88);
        cycle();
        drive(1'b1, 3'd4, 32'h99);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_full: got rdy=%b, required 0", in_ready);
        end
        rst_n = 1'b0;
        cycle();
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        drive(1'b0, 3'd0, '0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 8'h00 || in_ready !== 1'b1 || out_data !== '0) begin
                n_err++;
                $display("FAIL mid_reset i=%0d: got valid=%h rdy=%b data=%h, required 00/1/0",
                         i, out_valid, in_ready, out_data);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !in_ready)) begin
                if ($urandom_range(0, 3) != 0)
                    drive(1'b1, 3'($urandom_range(0, 7)), W'($urandom));
                else
                    drive(1'b0, 3'd0, '0);
            end
            out_ready = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            cycle();
        end
        drive(1'b0, 3'd0, '0);
        out_ready = 8'hFF;
        for (int i = 0; i < 4; i++) cycle();
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 8'h00) begin
            n_err++;
            $display("FAIL random_flush: got pending=%0d valid=%h, required 0/00", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        hold_pending = 1'b0;
        hold_valid   = 8'h00;
        hold_sel     = 3'd0;
        hold_data    = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrong_channel();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
